// File: rtl/hazard_unit_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hazard_unit_if
// Bundles the pipeline-side signals seen by the hazard controller.
//   master : the pipeline (drives register fields, stage flags, MULT/DIV start;
//            receives forward selects, stall/flush and MULT/DIV status)
//   slave  : hazard_unit (the reverse directions)
// Signals:
//   decode    : rs_decode, rt_decode, hi_lo_read_decode, multdiv_decode
//   execute   : rs_execute, rt_execute, write_reg_execute, mem_to_reg_execute,
//               hi_read_execute, lo_read_execute, multdiv_start_execute,
//               is_div_execute
//   memory    : reg_write_memory, write_reg_memory, hi_lo_write_memory
//   writeback : reg_write_writeback, write_reg_writeback, hi_lo_write_writeback
//   outputs   : forward_one_execute, forward_two_execute, stall_fetch,
//               stall_decode, flush_execute, multdiv_busy, multdiv_done
// -----------------------------------------------------------------------------
interface hazard_unit_if;
   logic [4:0] rs_decode;
   logic [4:0] rt_decode;
   logic       hi_lo_read_decode;
   logic       multdiv_decode;
   logic [4:0] rs_execute;
   logic [4:0] rt_execute;
   logic [4:0] write_reg_execute;
   logic       mem_to_reg_execute;
   logic       hi_read_execute;
   logic       lo_read_execute;
   logic       multdiv_start_execute;
   logic       is_div_execute;
   logic       reg_write_memory;
   logic [4:0] write_reg_memory;
   logic       hi_lo_write_memory;
   logic       reg_write_writeback;
   logic [4:0] write_reg_writeback;
   logic       hi_lo_write_writeback;
   logic [2:0] forward_one_execute;
   logic [2:0] forward_two_execute;
   logic       stall_fetch;
   logic       stall_decode;
   logic       flush_execute;
   logic       multdiv_busy;
   logic       multdiv_done;

   modport master (
      output rs_decode, rt_decode, hi_lo_read_decode, multdiv_decode,
             rs_execute, rt_execute, write_reg_execute, mem_to_reg_execute,
             hi_read_execute, lo_read_execute, multdiv_start_execute,
             is_div_execute, reg_write_memory, write_reg_memory,
             hi_lo_write_memory, reg_write_writeback, write_reg_writeback,
             hi_lo_write_writeback,
      input  forward_one_execute, forward_two_execute, stall_fetch,
             stall_decode, flush_execute, multdiv_busy, multdiv_done
   );

   modport slave (
      input  rs_decode, rt_decode, hi_lo_read_decode, multdiv_decode,
             rs_execute, rt_execute, write_reg_execute, mem_to_reg_execute,
             hi_read_execute, lo_read_execute, multdiv_start_execute,
             is_div_execute, reg_write_memory, write_reg_memory,
             hi_lo_write_memory, reg_write_writeback, write_reg_writeback,
             hi_lo_write_writeback,
      output forward_one_execute, forward_two_execute, stall_fetch,
             stall_decode, flush_execute, multdiv_busy, multdiv_done
   );
endinterface

// File: rtl/hazard_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hazard_unit
// Hazard controller for the 5-stage MIPS pipeline:
//   - execute-stage operand forwarding selects (GPR and HI/LO paths)
//   - load-use and MULT/DIV-consumer stall of fetch/decode with execute flush
//   - MULT/DIV sequencer producing registered busy and final-cycle done
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   hz      : hazard_unit_if.slave, all pipeline-side signals
// Forward select codes: 000 regfile, 001 WB result, 010 MEM ALU out,
//                       011 MEM LO/HI, 100 WB LO/HI.
// -----------------------------------------------------------------------------
module hazard_unit #(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   hazard_unit_if.slave hz
);

   localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [2:0] fwd_one, fwd_two;
   logic       load_use, md_hazard, stall;
   logic [CNT_W-1:0] load_val;

   // Priority: HI/LO memory, HI/LO writeback, GPR memory, GPR writeback.
   // $0 is hardwired zero, so it is never forwarded.
   function automatic logic [2:0] fwd_sel(
      input logic       hl_rd,
      input logic       hl_wm,
      input logic       hl_ww,
      input logic [4:0] src,
      input logic       rw_m,
      input logic [4:0] wr_m,
      input logic       rw_w,
      input logic [4:0] wr_w
   );
      if (hl_rd && hl_wm)                           return 3'b011;
      else if (hl_rd && hl_ww)                      return 3'b100;
      else if ((src != 5'd0) && rw_m && (wr_m == src)) return 3'b010;
      else if ((src != 5'd0) && rw_w && (wr_w == src)) return 3'b001;
      else                                          return 3'b000;
   endfunction

   always_comb begin
      fwd_one = fwd_sel(hz.lo_read_execute, hz.hi_lo_write_memory,
                        hz.hi_lo_write_writeback, hz.rs_execute,
                        hz.reg_write_memory, hz.write_reg_memory,
                        hz.reg_write_writeback, hz.write_reg_writeback);
      fwd_two = fwd_sel(hz.hi_read_execute, hz.hi_lo_write_memory,
                        hz.hi_lo_write_writeback, hz.rt_execute,
                        hz.reg_write_memory, hz.write_reg_memory,
                        hz.reg_write_writeback, hz.write_reg_writeback);
   end

   assign load_use  = hz.mem_to_reg_execute && (hz.write_reg_execute != 5'd0) &&
                      ((hz.write_reg_execute == hz.rs_decode) ||
                       (hz.write_reg_execute == hz.rt_decode));
   // A start in execute counts as busy already: the consumer in decode would
   // otherwise slip past before busy_q rises on the next edge.
   assign md_hazard = (hz.hi_lo_read_decode || hz.multdiv_decode) &&
                      (busy_q || hz.multdiv_start_execute);
   assign stall     = load_use || md_hazard;

   // Combinational outputs are held inactive while reset is asserted.
   assign hz.forward_one_execute = reset_n ? fwd_one : 3'b000;
   assign hz.forward_two_execute = reset_n ? fwd_two : 3'b000;
   assign hz.stall_fetch         = reset_n && stall;
   assign hz.stall_decode        = reset_n && stall;
   assign hz.flush_execute       = reset_n && stall;
   assign hz.multdiv_busy        = busy_q;
   assign hz.multdiv_done        = done_q;

   assign load_val = hz.is_div_execute ? DIV_LOAD : MULT_LOAD;

   // MULT/DIV sequencer: counter holds remaining busy cycles minus one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (hz.multdiv_start_execute) begin
               state_d = BUSY;
               cnt_d   = load_val;
               // Single-cycle operation: first busy cycle is also the last.
               done_d  = (load_val == '0);
            end
         end
         BUSY: begin
            // Starts are ignored here, including on the final busy cycle.
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d  = cnt_q - CNT_W'(1);
               done_d = (cnt_q == CNT_W'(1));
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == BUSY);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Directed bench for hazard_unit (MULT_CYCLES=4, DIV_CYCLES=32). Inputs are
// driven 1ns after the rising edge; outputs are sampled on the falling edge.
// Expected output sets are queued when a step is driven and popped/compared
// when the sample point is reached.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

   logic clk;
   logic reset_n;
   int   n_vec;
   int   n_err;

   hazard_unit_if hz ();

   hazard_unit #(
      .MULT_CYCLES (4),
      .DIV_CYCLES  (32)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .hz      (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [2:0] f1;
      logic [2:0] f2;
      logic       st;
      logic       bz;
      logic       dn;
   } exp_t;

   exp_t sbq[$];

   task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [2:0] f1, input logic [2:0] f2,
                           input logic st, input logic bz, input logic dn);
      exp_t e;
      e.tag = tag; e.f1 = f1; e.f2 = f2; e.st = st; e.bz = bz; e.dn = dn;
      sbq.push_back(e);
   endtask

   // Pop the oldest expectation and compare against the current DUT outputs.
   task automatic compare_head();
      exp_t e;
      if (sbq.size() == 0) begin
         n_vec++; n_err++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sbq.pop_front();
         chk({e.tag, ".fwd1"},  hz.forward_one_execute, e.f1);
         chk({e.tag, ".fwd2"},  hz.forward_two_execute, e.f2);
         chk({e.tag, ".stf"},   {2'b00, hz.stall_fetch},   {2'b00, e.st});
         chk({e.tag, ".std"},   {2'b00, hz.stall_decode},  {2'b00, e.st});
         chk({e.tag, ".flush"}, {2'b00, hz.flush_execute}, {2'b00, e.st});
         chk({e.tag, ".busy"},  {2'b00, hz.multdiv_busy},  {2'b00, e.bz});
         chk({e.tag, ".done"},  {2'b00, hz.multdiv_done},  {2'b00, e.dn});
      end
   endtask

   task automatic expect_now(input string tag, input logic [2:0] f1, input logic [2:0] f2,
                             input logic st, input logic bz, input logic dn);
      push_exp(tag, f1, f2, st, bz, dn);
      compare_head();
   endtask

   // Inputs already driven for this cycle; check at the falling edge, then
   // advance to 1ns after the next rising edge.
   task automatic step(input string tag, input logic [2:0] f1, input logic [2:0] f2,
                       input logic st, input logic bz, input logic dn);
      push_exp(tag, f1, f2, st, bz, dn);
      @(negedge clk);
      compare_head();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      hz.rs_decode = 5'd0;            hz.rt_decode = 5'd0;
      hz.hi_lo_read_decode = 1'b0;    hz.multdiv_decode = 1'b0;
      hz.rs_execute = 5'd0;           hz.rt_execute = 5'd0;
      hz.write_reg_execute = 5'd0;    hz.mem_to_reg_execute = 1'b0;
      hz.hi_read_execute = 1'b0;      hz.lo_read_execute = 1'b0;
      hz.multdiv_start_execute = 1'b0; hz.is_div_execute = 1'b0;
      hz.reg_write_memory = 1'b0;     hz.write_reg_memory = 5'd0;
      hz.hi_lo_write_memory = 1'b0;   hz.reg_write_writeback = 1'b0;
      hz.write_reg_writeback = 5'd0;  hz.hi_lo_write_writeback = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      reset_n = 1'b0;
      clr();
      // Inputs that would forward and stall: all must be masked in reset.
      hz.rs_execute = 5'd5; hz.reg_write_memory = 1'b1; hz.write_reg_memory = 5'd5;
      hz.mem_to_reg_execute = 1'b1; hz.write_reg_execute = 5'd8; hz.rt_decode = 5'd8;
      step("reset", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;

      // ---------------- forwarding ----------------
      clr();
      hz.rs_execute = 5'd5;
      hz.reg_write_memory = 1'b1;    hz.write_reg_memory = 5'd5;
      hz.reg_write_writeback = 1'b1; hz.write_reg_writeback = 5'd5;
      step("fwd_mem_over_wb", 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
      hz.reg_write_memory = 1'b0;
      step("fwd_wb_only", 3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
      hz.reg_write_memory = 1'b1;
      hz.rs_execute = 5'd6; hz.rt_execute = 5'd5;
      step("fwd_rt_mem", 3'b000, 3'b010, 1'b0, 1'b0, 1'b0);
      hz.rs_execute = 5'd0; hz.rt_execute = 5'd0;
      hz.write_reg_memory = 5'd0; hz.write_reg_writeback = 5'd0;
      step("fwd_r0_guard", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

      clr();
      hz.lo_read_execute = 1'b1; hz.hi_lo_write_memory = 1'b1;
      hz.rs_execute = 5'd5; hz.reg_write_memory = 1'b1; hz.write_reg_memory = 5'd5;
      step("fwd_lo_mem", 3'b011, 3'b000, 1'b0, 1'b0, 1'b0);
      hz.hi_lo_write_memory = 1'b0; hz.hi_lo_write_writeback = 1'b1;
      step("fwd_lo_wb", 3'b100, 3'b000, 1'b0, 1'b0, 1'b0);
      hz.lo_read_execute = 1'b0; hz.hi_read_execute = 1'b1; hz.rt_execute = 5'd5;
      step("fwd_hi_wb", 3'b010, 3'b100, 1'b0, 1'b0, 1'b0);
      hz.hi_lo_write_memory = 1'b1;
      step("fwd_hi_mem", 3'b010, 3'b011, 1'b0, 1'b0, 1'b0);

      // ---------------- load-use ----------------
      clr();
      hz.mem_to_reg_execute = 1'b1; hz.write_reg_execute = 5'd8; hz.rt_decode = 5'd8;
      step("ldu_rt", 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
      hz.mem_to_reg_execute = 1'b0; hz.write_reg_execute = 5'd0;  // bubble after flush
      step("ldu_bubble", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      hz.mem_to_reg_execute = 1'b1; hz.write_reg_execute = 5'd0;
      hz.rs_decode = 5'd0; hz.rt_decode = 5'd0;
      step("ldu_r0", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      hz.write_reg_execute = 5'd9; hz.rs_decode = 5'd9;
      step("ldu_rs", 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
      hz.rs_decode = 5'd3; hz.rt_decode = 5'd4;
      step("ldu_nomatch", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

      // ---------------- DIV sequence ----------------
      clr();
      hz.multdiv_start_execute = 1'b1; hz.is_div_execute = 1'b1; hz.hi_lo_read_decode = 1'b1;
      step("div_start", 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
      hz.multdiv_start_execute = 1'b0; hz.is_div_execute = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         hz.multdiv_decode    = (k % 2 == 1);
         hz.hi_lo_read_decode = (k % 2 == 0);
         step($sformatf("div_busy%0d", k), 3'b000, 3'b000, 1'b1, 1'b1, (k == 32));
      end
      hz.multdiv_decode = 1'b0; hz.hi_lo_read_decode = 1'b1;
      step("div_after", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

      // ---------------- reset mid-DIV ----------------
      clr();
      hz.multdiv_start_execute = 1'b1; hz.is_div_execute = 1'b1; hz.hi_lo_read_decode = 1'b1;
      step("div2_start", 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
      hz.multdiv_start_execute = 1'b0; hz.is_div_execute = 1'b0;
      for (int k = 1; k <= 9; k++)
         step($sformatf("div2_busy%0d", k), 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      expect_now("div2_busy10", 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
      #1 reset_n = 1'b0;
      #1 expect_now("rst_async", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 expect_now("rst_held", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      clr();
      step("idle_after_rst", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

      // ---------------- MULT after reset ----------------
      hz.multdiv_start_execute = 1'b1; hz.is_div_execute = 1'b0; hz.hi_lo_read_decode = 1'b1;
      step("mult_start", 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         // Start on the final busy cycle must be ignored.
         hz.multdiv_start_execute = (k == 4);
         step($sformatf("mult_busy%0d", k), 3'b000, 3'b000, 1'b1, 1'b1, (k == 4));
      end
      hz.multdiv_start_execute = 1'b0;
      step("mult_after", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      hz.hi_lo_read_decode = 1'b0;
      step("mult_idle", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It generates the execute-stage operand forwarding selects consumed by the ALU operand muxes. It detects load-use hazards and stalls fetch/decode while flushing execute. It also sequences the multi-cycle MULT/DIV unit with a busy counter, stalling HI/LO consumers until the result is written.

Parameters:
MULT_CYCLES, 4, execute cycles occupied by MULT/MULTU (>=1)
DIV_CYCLES, 32, execute cycles occupied by DIV/DIVU (>=1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
rs_decode  input  5  rs field of instruction in decode
rt_decode  input  5  rt field of instruction in decode
hi_lo_read_decode  input  1  decode instruction is MFHI/MFLO
multdiv_decode  input  1  decode instruction is MULT/MULTU/DIV/DIVU
rs_execute  input  5  rs field in execute
rt_execute  input  5  rt field in execute
write_reg_execute  input  5  destination register in execute
mem_to_reg_execute  input  1  execute instruction is a load
hi_read_execute  input  1  execute instruction is MFHI
lo_read_execute  input  1  execute instruction is MFLO
multdiv_start_execute  input  1  MULT/DIV entering execute this cycle
is_div_execute  input  1  qualifies start: 1=DIV, 0=MULT
reg_write_memory  input  1  memory-stage instruction writes GPR
write_reg_memory  input  5  memory-stage destination register
hi_lo_write_memory  input  1  memory-stage instruction writes HI/LO
reg_write_writeback  input  1  writeback-stage instruction writes GPR
write_reg_writeback  input  5  writeback-stage destination register
hi_lo_write_writeback  input  1  writeback-stage instruction writes HI/LO
forward_one_execute  output  3  operand A select
forward_two_execute  output  3  operand B select
stall_fetch  output  1  hold PC
stall_decode  output  1  hold fetch/decode pipeline register
flush_execute  output  1  insert bubble into decode/execute register
multdiv_busy  output  1  registered, MULT/DIV in progress
multdiv_done  output  1  registered, one-cycle pulse on final busy cycle

Behaviour:
- Clock/reset: one clock, clk; reset_n asynchronous active-low. While reset_n=0: state IDLE, counter 0, multdiv_busy=0, multdiv_done=0; stall_fetch, stall_decode, flush_execute forced 0; forward selects forced 000.
- Operand A select, combinational, first match wins:
  - lo_read_execute & hi_lo_write_memory -> 011 (ALU LO output, memory stage)
  - lo_read_execute & hi_lo_write_writeback -> 100 (LO result, writeback)
  - rs_execute!=0 & reg_write_memory & write_reg_memory==rs_execute -> 010 (ALU output, memory)
  - rs_execute!=0 & reg_write_writeback & write_reg_writeback==rs_execute -> 001 (writeback result)
  - otherwise -> 000 (register file)
- Operand B select: same priority using hi_read_execute and rt_execute. HI memory -> 011, HI writeback -> 100, GPR memory -> 010, GPR writeback -> 001, otherwise 000. Codes 101-111 never driven.
- Memory stage always beats writeback when both match. Register $0 is never forwarded.
- Load-use hazard: mem_to_reg_execute & write_reg_execute!=0 & (write_reg_execute==rs_decode | write_reg_execute==rt_decode).
- MULT/DIV hazard: (hi_lo_read_decode | multdiv_decode) & (multdiv_busy | multdiv_start_execute).
- stall = load-use hazard OR MULT/DIV hazard. stall_fetch = stall_decode = flush_execute = stall, all combinational, same cycle.
- MULT/DIV sequencer FSM:
  - IDLE: multdiv_start_execute -> BUSY. Counter loads DIV_CYCLES-1 if is_div_execute, else MULT_CYCLES-1. multdiv_busy=1 from the next edge.
  - BUSY: counter decrements each cycle. When counter==1, multdiv_done=1 on the next edge, which is the final busy cycle. When counter==0, go to IDLE and multdiv_busy=0.
  - Latency-1 case: load value 0; busy and done are each high for exactly one cycle.
  - multdiv_start_execute while BUSY is ignored; the stall makes this unreachable in a legal pipeline.
  - Start in the same cycle the FSM returns to IDLE: not accepted. Start is sampled only in IDLE, so decode is stalled for one extra cycle.
- reset_n asserted mid-operation aborts the sequence immediately; no done pulse is produced.

Test Plan:
- Forwarding, memory over writeback: rs_execute=5, memory writes r5, writeback writes r5 -> forward_one_execute=010. Drop the memory write -> 001.
- $0 guard: rt_execute=0, memory writes r0 -> forward_two_execute=000. rs_execute=0 -> forward_one_execute=000.
- HI/LO forwarding: MFLO in execute, hi_lo_write_memory=1 -> forward_one=011. MFHI with writeback only -> forward_two=100.
- Load-use: load to r8 in execute, rt_decode=8 -> stall_fetch, stall_decode, flush_execute =1 for exactly one cycle. Destination r0 -> no stall.
- DIV sequencing (DIV_CYCLES=32): start DIV with MFHI in decode -> stall for 33 cycles total. multdiv_busy high 32 cycles, multdiv_done pulses once on its last cycle, stall drops the cycle after busy falls.
- Reset mid-DIV: assert reset_n=0 at busy cycle 10 -> busy/done 0 asynchronously. After release, FSM is IDLE and a MULT start completes in MULT_CYCLES=4 cycles.
